// File: rtl/demodchest_pilot_est.sv
// -----------------------------------------------------------------------------
// demodchest_pilot_est
//
// Streaming channel-estimation stage between the demodchest NoC shell input
// port and the demodulator core. Every input packet starts with PILOT_LEN
// pilot samples (sc16, transmitted symbol +1+0j). The pilots are averaged
// into one complex channel estimate and consumed. The output packet is the
// estimate word followed by the untouched payload samples. The sideband
// length is rewritten to match.
//
// Ports
//   axis_data_clk / axis_data_rst_n : clock, synchronous active-low reset
//   s_axis_*  : input sample stream (sc16: I [31:16], Q [15:0]) + sideband
//   m_axis_*  : output stream [estimate, payload...] + sideband, held stable
//               for the whole output packet
//   chan_est / chan_est_stb : last estimate and its one-cycle update strobe
//   err_short : one-cycle pulse when a packet shorter than the pilot block
//               is dropped
//   pkt_cnt / drop_cnt : wrapping counters of output packets / drops
// -----------------------------------------------------------------------------
module demodchest_pilot_est #(
  parameter int PILOT_LEN = 16,
  parameter int CNT_W     = 32
) (
  input  logic             axis_data_clk,
  input  logic             axis_data_rst_n,
  input  logic [31:0]      s_axis_tdata,
  input  logic             s_axis_tkeep,
  input  logic             s_axis_tlast,
  input  logic             s_axis_tvalid,
  output logic             s_axis_tready,
  input  logic [63:0]      s_axis_ttimestamp,
  input  logic             s_axis_thas_time,
  input  logic [15:0]      s_axis_tlength,
  input  logic             s_axis_teov,
  input  logic             s_axis_teob,
  output logic [31:0]      m_axis_tdata,
  output logic             m_axis_tkeep,
  output logic             m_axis_tlast,
  output logic             m_axis_tvalid,
  input  logic             m_axis_tready,
  output logic [63:0]      m_axis_ttimestamp,
  output logic             m_axis_thas_time,
  output logic [15:0]      m_axis_tlength,
  output logic             m_axis_teov,
  output logic             m_axis_teob,
  output logic [31:0]      chan_est,
  output logic             chan_est_stb,
  output logic             err_short,
  output logic [CNT_W-1:0] pkt_cnt,
  output logic [CNT_W-1:0] drop_cnt
);

  localparam int LOG2  = $clog2(PILOT_LEN);
  localparam int ACC_W = 16 + LOG2;
  // The output packet loses PILOT_LEN samples and gains one estimate word.
  localparam logic [15:0] LEN_SHRINK = 16'(4 * PILOT_LEN - 4);
  localparam logic [LOG2-1:0] IDX_LAST = LOG2'(PILOT_LEN - 1);

  typedef enum logic [1:0] {
    ST_PILOT,
    ST_EST,
    ST_DATA
  } state_t;

  state_t                  state_q, state_d;
  logic signed [ACC_W-1:0] acc_re_q, acc_re_d;
  logic signed [ACC_W-1:0] acc_im_q, acc_im_d;
  logic [LOG2-1:0]         idx_q, idx_d;
  logic [31:0]             est_q, est_d;
  logic                    est_last_q, est_last_d;
  logic                    stb_q, stb_d;
  logic                    err_q, err_d;
  logic [CNT_W-1:0]        pkt_cnt_q, pkt_cnt_d;
  logic [CNT_W-1:0]        drop_cnt_q, drop_cnt_d;
  logic [63:0]             ts_q, ts_d;
  logic                    has_time_q, has_time_d;
  logic [15:0]             len_q, len_d;
  logic                    eov_q, eov_d;
  logic                    eob_q, eob_d;

  // Running sums including the beat currently presented. The accumulators
  // are LOG2 bits wider than a sample, so PILOT_LEN adds can never overflow.
  logic signed [ACC_W-1:0] sum_re, sum_im;
  assign sum_re = acc_re_q + {{LOG2{s_axis_tdata[31]}}, s_axis_tdata[31:16]};
  assign sum_im = acc_im_q + {{LOG2{s_axis_tdata[15]}}, s_axis_tdata[15:0]};

  // Dividing by PILOT_LEN is an arithmetic shift; keeping only the upper
  // 16 bits is that shift plus truncation, so results round toward -inf.
  // The discarded fraction bits and tkeep are intentionally unused.
  logic unused_bits;
  assign unused_bits = &{1'b0, s_axis_tkeep, sum_re[LOG2-1:0], sum_im[LOG2-1:0]};

  // NOTE: every signal written here gets a default first, so no path through
  // the case statement can leave one unassigned and infer a latch.
  always_comb begin
    state_d       = state_q;
    acc_re_d      = acc_re_q;
    acc_im_d      = acc_im_q;
    idx_d         = idx_q;
    est_d         = est_q;
    est_last_d    = est_last_q;
    stb_d         = 1'b0;
    err_d         = 1'b0;
    pkt_cnt_d     = pkt_cnt_q;
    drop_cnt_d    = drop_cnt_q;
    ts_d          = ts_q;
    has_time_d    = has_time_q;
    len_d         = len_q;
    eov_d         = eov_q;
    eob_d         = eob_q;
    s_axis_tready = 1'b0;
    m_axis_tvalid = 1'b0;
    m_axis_tdata  = '0;
    m_axis_tlast  = 1'b0;

    unique case (state_q)
      ST_PILOT: begin
        s_axis_tready = 1'b1;
        if (s_axis_tvalid) begin
          acc_re_d = sum_re;
          acc_im_d = sum_im;
          idx_d    = idx_q + LOG2'(1);
          // Sideband belongs to the packet, so capture it on its first beat.
          if (idx_q == '0) begin
            ts_d       = s_axis_ttimestamp;
            has_time_d = s_axis_thas_time;
            eov_d      = s_axis_teov;
            eob_d      = s_axis_teob;
            len_d      = s_axis_tlength - LEN_SHRINK;
          end
          if (idx_q == IDX_LAST) begin
            est_d      = {sum_re[ACC_W-1:LOG2], sum_im[ACC_W-1:LOG2]};
            est_last_d = s_axis_tlast;
            stb_d      = 1'b1;
            state_d    = ST_EST;
          end else if (s_axis_tlast) begin
            // Packet ended inside the pilot block: nothing usable, drop it.
            err_d      = 1'b1;
            drop_cnt_d = drop_cnt_q + CNT_W'(1);
            acc_re_d   = '0;
            acc_im_d   = '0;
            idx_d      = '0;
          end
        end
      end

      ST_EST: begin
        m_axis_tvalid = 1'b1;
        m_axis_tdata  = est_q;
        m_axis_tlast  = est_last_q;
        if (m_axis_tready) begin
          acc_re_d = '0;
          acc_im_d = '0;
          idx_d    = '0;
          if (est_last_q) begin
            pkt_cnt_d = pkt_cnt_q + CNT_W'(1);
            state_d   = ST_PILOT;
          end else begin
            state_d = ST_DATA;
          end
        end
      end

      ST_DATA: begin
        m_axis_tvalid = s_axis_tvalid;
        s_axis_tready = m_axis_tready;
        m_axis_tdata  = s_axis_tdata;
        m_axis_tlast  = s_axis_tlast;
        if (s_axis_tvalid && m_axis_tready && s_axis_tlast) begin
          pkt_cnt_d = pkt_cnt_q + CNT_W'(1);
          state_d   = ST_PILOT;
        end
      end

      default: state_d = ST_PILOT;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge value of every other flop, independent of evaluation order.
  always_ff @(posedge axis_data_clk) begin
    if (!axis_data_rst_n) begin
      state_q    <= ST_PILOT;
      acc_re_q   <= '0;
      acc_im_q   <= '0;
      idx_q      <= '0;
      est_q      <= '0;
      est_last_q <= 1'b0;
      stb_q      <= 1'b0;
      err_q      <= 1'b0;
      pkt_cnt_q  <= '0;
      drop_cnt_q <= '0;
      ts_q       <= '0;
      has_time_q <= 1'b0;
      len_q      <= '0;
      eov_q      <= 1'b0;
      eob_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      acc_re_q   <= acc_re_d;
      acc_im_q   <= acc_im_d;
      idx_q      <= idx_d;
      est_q      <= est_d;
      est_last_q <= est_last_d;
      stb_q      <= stb_d;
      err_q      <= err_d;
      pkt_cnt_q  <= pkt_cnt_d;
      drop_cnt_q <= drop_cnt_d;
      ts_q       <= ts_d;
      has_time_q <= has_time_d;
      len_q      <= len_d;
      eov_q      <= eov_d;
      eob_q      <= eob_d;
    end
  end

  assign m_axis_tkeep      = 1'b1;
  assign m_axis_ttimestamp = ts_q;
  assign m_axis_thas_time  = has_time_q;
  assign m_axis_tlength    = len_q;
  assign m_axis_teov       = eov_q;
  assign m_axis_teob       = eob_q;
  assign chan_est          = est_q;
  assign chan_est_stb      = stb_q;
  assign err_short         = err_q;
  assign pkt_cnt           = pkt_cnt_q;
  assign drop_cnt          = drop_cnt_q;

endmodule

// File: tb/tb_demodchest_pilot_est.sv
// -----------------------------------------------------------------------------
// tb_demodchest_pilot_est
//
// Self-checking bench for demodchest_pilot_est with PILOT_LEN=4. A table of
// packet vectors with hand-computed estimates and lengths is streamed and
// compared, followed by hand-written sequences for short-packet drop,
// random backpressure and reset mid-packet.
// -----------------------------------------------------------------------------
module tb_demodchest_pilot_est;

  localparam int PL = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] s_tdata;
  logic        s_tlast, s_tvalid, s_tready;
  logic [63:0] s_ts;
  logic        s_has_time, s_eov, s_eob;
  logic [15:0] s_len;
  logic [31:0] m_tdata;
  logic        m_tkeep, m_tlast, m_tvalid, m_rdy;
  logic [63:0] m_ts;
  logic        m_has_time, m_eov, m_eob;
  logic [15:0] m_len;
  logic [31:0] chan_est;
  logic        chan_est_stb, err_short;
  logic [31:0] pkt_cnt, drop_cnt;

  always #5 clk = ~clk;

  demodchest_pilot_est #(.PILOT_LEN(PL), .CNT_W(32)) dut (
    .axis_data_clk    (clk),
    .axis_data_rst_n  (rst_n),
    .s_axis_tdata     (s_tdata),
    .s_axis_tkeep     (1'b1),
    .s_axis_tlast     (s_tlast),
    .s_axis_tvalid    (s_tvalid),
    .s_axis_tready    (s_tready),
    .s_axis_ttimestamp(s_ts),
    .s_axis_thas_time (s_has_time),
    .s_axis_tlength   (s_len),
    .s_axis_teov      (s_eov),
    .s_axis_teob      (s_eob),
    .m_axis_tdata     (m_tdata),
    .m_axis_tkeep     (m_tkeep),
    .m_axis_tlast     (m_tlast),
    .m_axis_tvalid    (m_tvalid),
    .m_axis_tready    (m_rdy),
    .m_axis_ttimestamp(m_ts),
    .m_axis_thas_time (m_has_time),
    .m_axis_tlength   (m_len),
    .m_axis_teov      (m_eov),
    .m_axis_teob      (m_eob),
    .chan_est         (chan_est),
    .chan_est_stb     (chan_est_stb),
    .err_short        (err_short),
    .pkt_cnt          (pkt_cnt),
    .drop_cnt         (drop_cnt)
  );

  typedef struct packed {
    logic [3:0][31:0] pilots;
    logic [7:0]       n_pay;
    logic [15:0]      tlength;
    logic [31:0]      exp_est;
    logic [15:0]      exp_len;
  } vec_t;

  vec_t vecs [6];

  int n_checks = 0;
  int n_fail   = 0;

  // Stimulus / capture state shared with run_pkt.
  logic [31:0] in_data[$];
  logic        in_last[$];
  logic [31:0] out_data[$];
  logic        out_last[$];
  int          stb_cnt, err_cnt, hs_viol, est_rdy_viol, timeouts;
  logic [63:0] cap_ts;
  logic        cap_has_time, cap_eob, cap_eov;
  logic [15:0] cap_len;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [3:0][31:0] mk4(input logic [31:0] a, input logic [31:0] b,
                                          input logic [31:0] c, input logic [31:0] d);
    return {d, c, b, a};
  endfunction

  // Reference estimate: floor of the mean of the pilot I and Q parts.
  function automatic logic [31:0] model_est(input logic [3:0][31:0] p);
    int si = 0;
    int sq = 0;
    for (int k = 0; k < PL; k++) begin
      si = si + int'($signed(p[k][31:16]));
      sq = sq + int'($signed(p[k][15:0]));
    end
    si = si >>> 2;
    sq = sq >>> 2;
    return {si[15:0], sq[15:0]};
  endfunction

  function automatic logic [31:0] pay_word(input logic [31:0] base, input int k);
    return base + 32'(k) * 32'h0001_0001;
  endfunction

  task automatic load_pkt(input logic [3:0][31:0] p, input int n_pay, input logic [31:0] base);
    in_data.delete();
    in_last.delete();
    for (int k = 0; k < PL; k++) begin
      in_data.push_back(p[k]);
      in_last.push_back(n_pay == 0 && k == PL - 1);
    end
    for (int k = 0; k < n_pay; k++) begin
      in_data.push_back(pay_word(base, k));
      in_last.push_back(k == n_pay - 1);
    end
  endtask

  // Streams in_data, collects the output packet. Starts and ends at posedge+1.
  task automatic run_pkt(input int exp_out, input int ready_pct);
    int   cyc   = 0;
    int   drain = 0;
    logic prev_stall = 1'b0;
    logic [31:0] prev_data = '0;
    logic        prev_last = 1'b0;
    out_data.delete();
    out_last.delete();
    stb_cnt = 0;
    err_cnt = 0;
    while (drain < 4 && cyc < 2000) begin
      if (in_data.size() > 0) begin
        s_tvalid = 1'b1;
        s_tdata  = in_data[0];
        s_tlast  = in_last[0];
      end else begin
        s_tvalid = 1'b0;
        s_tdata  = '0;
        s_tlast  = 1'b0;
      end
      m_rdy = ($urandom_range(0, 99) < ready_pct);
      @(negedge clk);
      if (chan_est_stb) stb_cnt++;
      if (err_short) err_cnt++;
      if (prev_stall && (!m_tvalid || m_tdata !== prev_data || m_tlast !== prev_last))
        hs_viol++;
      if (m_tvalid && out_data.size() == 0 && s_tready) est_rdy_viol++;
      if (s_tvalid && s_tready) begin
        void'(in_data.pop_front());
        void'(in_last.pop_front());
      end
      if (m_tvalid && m_rdy) begin
        out_data.push_back(m_tdata);
        out_last.push_back(m_tlast);
        if (m_tlast) begin
          cap_ts       = m_ts;
          cap_has_time = m_has_time;
          cap_len      = m_len;
          cap_eob      = m_eob;
          cap_eov      = m_eov;
        end
      end
      prev_stall = m_tvalid && !m_rdy;
      prev_data  = m_tdata;
      prev_last  = m_tlast;
      if (in_data.size() == 0 && out_data.size() >= exp_out) drain++;
      cyc++;
      step();
    end
    if (cyc >= 2000) timeouts++;
    s_tvalid = 1'b0;
    m_rdy    = 1'b1;
  endtask

  initial begin
    int          exp_pkt;
    int          errs;
    logic [3:0][31:0] p;
    logic [31:0] exp_pay[$];

    // Vector table: pilots in order, payload count, input tlength,
    // hand-computed estimate and output tlength.
    vecs[0] = '{pilots: mk4(32'h0064FFCE, 32'h0066FFD0, 32'h0062FFCC, 32'h0064FFCE),
                n_pay: 8'd6, tlength: 16'd40, exp_est: 32'h0064FFCE, exp_len: 16'd28};
    vecs[1] = '{pilots: mk4(32'hFFFDFFFF, 32'hFFFDFFFF, 32'hFFFDFFFF, 32'hFFFDFFFF),
                n_pay: 8'd1, tlength: 16'd20, exp_est: 32'hFFFDFFFF, exp_len: 16'd8};
    vecs[2] = '{pilots: mk4(32'hFFFF0000, 32'h0, 32'h0, 32'h0),
                n_pay: 8'd1, tlength: 16'd20, exp_est: 32'hFFFF0000, exp_len: 16'd8};
    vecs[3] = '{pilots: mk4(32'h00040008, 32'h00040008, 32'h00040008, 32'h00040008),
                n_pay: 8'd0, tlength: 16'd16, exp_est: 32'h00040008, exp_len: 16'd4};
    vecs[4] = '{pilots: mk4(32'h0001FFFF, 32'h0002FFFE, 32'h0003FFFD, 32'h0005FFFB),
                n_pay: 8'd2, tlength: 16'd24, exp_est: 32'h0002FFFD, exp_len: 16'd12};
    vecs[5] = '{pilots: mk4(32'h7FFF8000, 32'h7FFF8000, 32'h7FFF8000, 32'h7FFF8000),
                n_pay: 8'd1, tlength: 16'd20, exp_est: 32'h7FFF8000, exp_len: 16'd8};

    hs_viol = 0; est_rdy_viol = 0; timeouts = 0;
    rst_n = 1'b0; s_tvalid = 1'b0; s_tdata = '0; s_tlast = 1'b0; m_rdy = 1'b1;
    s_ts = '0; s_has_time = 1'b0; s_len = '0; s_eov = 1'b0; s_eob = 1'b0;
    step(); step();
    @(negedge clk);
    check("rst_s_tready", s_tready, 1);
    check("rst_m_out", {m_tvalid, m_tlast, m_tdata}, 0);
    check("rst_sideband", {m_ts, m_has_time, m_len, m_eov, m_eob}, 0);
    check("rst_status", {chan_est, chan_est_stb, err_short}, 0);
    check("rst_counters", {pkt_cnt, drop_cnt}, 0);
    check("m_tkeep", m_tkeep, 1);
    step();
    rst_n = 1'b1;
    exp_pkt = 0;

    // Table-driven packets, full-rate downstream.
    for (int v = 0; v < 6; v++) begin
      s_ts = 64'hA5A5_0000_0000_0100 + 64'(v);
      s_has_time = v[0];
      s_eov = v[1];
      s_eob = 1'b0;
      s_len = vecs[v].tlength;
      load_pkt(vecs[v].pilots, int'(vecs[v].n_pay), 32'h0001_0002);
      run_pkt(1 + int'(vecs[v].n_pay), 100);
      exp_pkt++;
      errs = 0;
      for (int k = 0; k < out_data.size(); k++) begin
        if (k > 0 && out_data[k] !== pay_word(32'h0001_0002, k - 1)) errs++;
        if (out_last[k] !== (k == out_data.size() - 1)) errs++;
      end
      check($sformatf("v%0d_words", v), out_data.size(), 1 + int'(vecs[v].n_pay));
      if (out_data.size() > 0) check($sformatf("v%0d_est", v), out_data[0], vecs[v].exp_est);
      check($sformatf("v%0d_payload_last", v), errs, 0);
      check($sformatf("v%0d_len", v), cap_len, vecs[v].exp_len);
      check($sformatf("v%0d_ts", v), {cap_ts, cap_has_time, cap_eov}, {s_ts, s_has_time, s_eov});
      check($sformatf("v%0d_stb", v), stb_cnt, 1);
      check($sformatf("v%0d_chan_est", v), chan_est, vecs[v].exp_est);
      check($sformatf("v%0d_pkt_cnt", v), pkt_cnt, exp_pkt);
    end

    // Short packet then a normal one: drop, then clean accumulators.
    s_len = 16'd12;
    in_data.delete(); in_last.delete();
    for (int k = 0; k < 3; k++) begin
      in_data.push_back(32'h03E8_03E8);
      in_last.push_back(k == 2);
    end
    run_pkt(0, 100);
    check("short_no_output", out_data.size(), 0);
    check("short_err_pulse", err_cnt, 1);
    check("short_no_stb", stb_cnt, 0);
    check("short_drop_cnt", drop_cnt, 1);
    s_len = 16'd24;
    load_pkt(mk4(32'h000A0014, 32'h000A0014, 32'h000A0014, 32'h000A0014), 2, 32'h0001_0002);
    run_pkt(3, 100);
    exp_pkt++;
    check("after_short_words", out_data.size(), 3);
    if (out_data.size() > 0) check("after_short_est", out_data[0], 32'h000A0014);
    check("after_short_pkt_cnt", pkt_cnt, exp_pkt);

    // Random backpressure over 100 packets of 20 samples.
    errs = 0;
    hs_viol = 0;
    est_rdy_viol = 0;
    s_len = 16'd80;
    for (int n = 0; n < 100; n++) begin
      s_ts = (n == 99) ? 64'h1234 : 64'h0;
      s_has_time = (n == 99);
      s_eob = (n == 99);
      s_eov = 1'b0;
      for (int k = 0; k < PL; k++) p[k] = $urandom;
      in_data.delete(); in_last.delete(); exp_pay.delete();
      for (int k = 0; k < PL; k++) begin
        in_data.push_back(p[k]);
        in_last.push_back(1'b0);
      end
      for (int k = 0; k < 16; k++) begin
        exp_pay.push_back($urandom);
        in_data.push_back(exp_pay[k]);
        in_last.push_back(k == 15);
      end
      run_pkt(17, 50);
      if (out_data.size() != 17) errs++;
      else begin
        if (out_data[0] !== model_est(p) || out_last[0] !== 1'b0) errs++;
        for (int k = 1; k < 17; k++)
          if (out_data[k] !== exp_pay[k - 1] || out_last[k] !== (k == 16)) errs++;
      end
      if (cap_len !== 16'd68) errs++;
    end
    exp_pkt += 100;
    check("bp_data_errors", errs, 0);
    check("bp_stable_while_stalled", hs_viol, 0);
    check("bp_s_tready_in_est", est_rdy_viol, 0);
    check("bp_pkt_cnt", pkt_cnt, exp_pkt);
    check("bp_last_sideband", {cap_ts, cap_has_time, cap_eob}, {64'h1234, 1'b1, 1'b1});

    // Reset during DATA of a packet.
    s_ts = '0; s_has_time = 1'b0; s_eob = 1'b0; s_len = 16'd32;
    m_rdy = 1'b1;
    s_tvalid = 1'b1;
    s_tlast = 1'b0;
    s_tdata = 32'h0005_0005;
    for (int k = 0; k < PL; k++) step();
    s_tdata = 32'h1111_2222;
    step();
    step();
    s_tdata = 32'h3333_4444;
    @(negedge clk);
    check("mid_pkt_in_data", {m_tvalid, m_tdata}, {1'b1, 32'h3333_4444});
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    s_tvalid = 1'b0;
    @(negedge clk);
    check("rst_mid_tvalid", m_tvalid, 0);
    check("rst_mid_counters", {pkt_cnt, drop_cnt, chan_est}, 0);
    step();
    s_len = 16'd28;
    load_pkt(mk4(32'h0007FFF9, 32'h0007FFF9, 32'h0007FFF9, 32'h0007FFF9), 3, 32'h0001_0002);
    run_pkt(4, 100);
    errs = 0;
    for (int k = 1; k < out_data.size(); k++)
      if (out_data[k] !== pay_word(32'h0001_0002, k - 1)) errs++;
    check("post_rst_words", out_data.size(), 4);
    if (out_data.size() > 0) check("post_rst_est", out_data[0], 32'h0007FFF9);
    check("post_rst_payload", errs, 0);
    check("post_rst_pkt_cnt", pkt_cnt, 1);
    check("no_timeouts", timeouts, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
